keycode_repeat_gen: RTL

//  Consumes the 8-bit keycode level driven by the software-written keycode PIO output port.

---
 rtl/keycode_repeat_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/keycode_repeat_gen.sv
// Turns a held keycode level into press, typematic repeat and release pulses.
// Two stages: an input register, then an FSM whose outputs are all registered.
module keycode_repeat_gen #(
    parameter int DELAY_CYCLES = 25_000_000,
    parameter int RATE_CYCLES  = 5_000_000,
    parameter int CNT_W        = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode_in,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_repeat,
    output logic       release_valid,
    output logic [7:0] release_code,
    output logic [7:0] held_code,
    output logic       key_down
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RPT
    } state_t;

    localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LD = CNT_W'(RATE_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [7:0]       key_q;
    logic [7:0]       held_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    logic       ev_n;
    logic [7:0] ec_n;
    logic       rpt_n;
    logic       rel_n;
    logic [7:0] rc_n;
    logic       kd_n;

    // Stage 1: capture the PIO level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q <= 8'h00;
        end else begin
            key_q <= keycode_in;
        end
    end

    // State register with the repeat counter and the held key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            held_code <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            held_code <= held_n;
        end
    end

    // Next state: release beats replace, replace beats repeat expiry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        held_n  = held_code;
        case (state)
            IDLE: begin
                if (key_q != 8'h00) begin
                    state_n = DELAY;
                    cnt_n   = DLY_LD;
                    held_n  = key_q;
                end
            end
            DELAY, RPT: begin
                if (key_q == 8'h00) begin
                    state_n = IDLE;
                    held_n  = 8'h00;
                end else if (key_q != held_code) begin
                    state_n = DELAY;
                    cnt_n   = DLY_LD;
                    held_n  = key_q;
                end else if (cnt == '0) begin
                    state_n = RPT;
                    cnt_n   = RPT_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                held_n  = 8'h00;
            end
        endcase
    end

    // Next values of the registered event outputs, same priority order.
    always_comb begin
        ev_n  = 1'b0;
        ec_n  = event_code;
        rpt_n = event_repeat;
        rel_n = 1'b0;
        rc_n  = release_code;
        kd_n  = (state_n != IDLE);
        case (state)
            IDLE: begin
                if (key_q != 8'h00) begin
                    ev_n  = 1'b1;
                    ec_n  = key_q;
                    rpt_n = 1'b0;
                end
            end
            DELAY, RPT: begin
                if (key_q == 8'h00) begin
                    rel_n = 1'b1;
                    rc_n  = held_code;
                end else if (key_q != held_code) begin
                    rel_n = 1'b1;
                    rc_n  = held_code;
                    ev_n  = 1'b1;
                    ec_n  = key_q;
                    rpt_n = 1'b0;
                end else if (cnt == '0) begin
                    ev_n  = 1'b1;
                    ec_n  = held_code;
                    rpt_n = 1'b1;
                end
            end
            default: begin
                ev_n = 1'b0;
            end
        endcase
    end

    // Output registers; pulses last exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_valid   <= 1'b0;
            event_code    <= 8'h00;
            event_repeat  <= 1'b0;
            release_valid <= 1'b0;
            release_code  <= 8'h00;
            key_down      <= 1'b0;
        end else begin
            event_valid   <= ev_n;
            event_code    <= ec_n;
            event_repeat  <= rpt_n;
            release_valid <= rel_n;
            release_code  <= rc_n;
            key_down      <= kd_n;
        end
    end

endmodule
